// File: rtl/tdc_stim_pkg.sv
// Shared definitions for the TDC start/stop stimulus generator:
// FSM encoding, field widths and the default repeat hold-off.
package tdc_stim_pkg;

  localparam int N_W         = 6;
  localparam int CNT_W       = 4;
  localparam int HOLDOFF_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STOP  = 3'd3,
    ST_HOLD  = 3'd4
  } tdc_state_e;

endpackage

// File: rtl/tdc_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module tdc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tdc_stim_gen.sv
// Start/stop pulse pair generator for exercising a TDC: programmable
// interval N, optional repeat bursts separated by HOLDOFF idle cycles.
module tdc_stim_gen
  import tdc_stim_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  localparam logic [N_W-1:0] HOLD_LOAD = N_W'(HOLDOFF - 1);

  logic             go_s;
  logic             go_prev;
  logic [1:0]       settle_q;
  logic             armed;
  logic             go_rise;

  tdc_state_e       state_q;
  tdc_state_e       state_nx;
  logic [N_W-1:0]   cnt_q;
  logic [N_W-1:0]   cnt_nx;
  logic [N_W-1:0]   n_q;
  logic             rep_q;
  logic             stop_evt;
  logic             load_n;

  logic             start_q, stop_q, busy_q, done_q;
  logic             start_nx, stop_nx, busy_nx, done_nx;
  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] burst_nx;

  tdc_sync2 u_go_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ui_in[6]),
    .q     (go_s)
  );

  // The synchroniser refills from 0 after reset; edges are only trusted once
  // it has settled, so a go level held through reset never looks like a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_prev  <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      go_prev <= go_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign armed   = (settle_q == 2'd3);
  assign go_rise = go_s & ~go_prev & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // A zero interval finishes the burst in the START cycle itself.
  assign stop_evt = (state_q == ST_STOP) || ((state_q == ST_START) && (n_q == '0));
  assign load_n   = (state_nx == ST_START) && (state_q != ST_START);

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    case (state_q)
      ST_IDLE:  if (go_rise) state_nx = ST_START;
      ST_START: begin
        if (n_q == N_W'(1)) begin
          state_nx = ST_STOP;
        end else if (n_q != '0) begin
          state_nx = ST_WAIT;
          cnt_nx   = n_q - N_W'(2);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_nx = ST_STOP;
        else             cnt_nx   = cnt_q - N_W'(1);
      end
      ST_STOP:  ;
      ST_HOLD: begin
        if (cnt_q == '0) state_nx = go_s ? ST_START : ST_IDLE;
        else             cnt_nx   = cnt_q - N_W'(1);
      end
      default:  state_nx = ST_IDLE;
    endcase
    if (stop_evt) begin
      if (rep_q && go_s) begin
        state_nx = ST_HOLD;
        cnt_nx   = HOLD_LOAD;
      end else begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      n_q   <= '0;
      rep_q <= 1'b0;
    end else begin
      cnt_q <= cnt_nx;
      if (load_n) n_q <= ui_in[N_W-1:0];
      if (load_n && (state_q == ST_IDLE)) rep_q <= ui_in[7];
    end
  end

  // Outputs are computed from the next state so every uo_out bit is a flop.
  always_comb begin
    start_nx = (state_nx == ST_START);
    stop_nx  = (state_nx == ST_STOP) || (load_n && (ui_in[N_W-1:0] == '0));
    busy_nx  = (state_nx != ST_IDLE);
    done_nx  = done_q;
    if (stop_evt)    done_nx = 1'b1;
    else if (load_n) done_nx = 1'b0;
    burst_nx = stop_nx ? burst_q + CNT_W'(1) : burst_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      start_q <= start_nx;
      stop_q  <= stop_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      burst_q <= burst_nx;
    end
  end

  assign uo_out = {burst_q, done_q, busy_q, stop_q, start_q};

endmodule

// File: tb/tb_tdc_stim_gen.sv
// Directed bench for tdc_stim_gen: latency, intervals, repeat period,
// async reset, ignored re-trigger and burst-count wrap.
module tb_tdc_stim_gen;

  localparam int HOLDOFF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  int   n_start = 0, n_stop = 0, busy_tot = 0;
  int   t_start = 0, t_stop = 0;
  int   start_long = 0, stop_long = 0;
  logic prev_start = 1'b0, prev_stop = 1'b0;

  int s0, p0, b0, t1, t2, t3;

  tdc_stim_gen #(.HOLDOFF(HOLDOFF)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: pulse times, pulse counts, busy-cycle total, over-long pulses.
  always @(negedge clk) begin
    if (uo_out[0]) begin n_start = n_start + 1; t_start = cyc; end
    if (uo_out[1]) begin n_stop = n_stop + 1; t_stop = cyc; end
    if (uo_out[2]) busy_tot = busy_tot + 1;
    if (uo_out[0] && prev_start) start_long = start_long + 1;
    if (uo_out[1] && prev_stop)  stop_long  = stop_long + 1;
    prev_start = uo_out[0];
    prev_stop  = uo_out[1];
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    if (obs == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_bit(input int b, input int budget, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      step(1);
      if (uo_out[b]) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h00;
    step(2);
    check("reset_uo", int'(uo_out), 0);
    rst_n = 1'b1;
    step(3);
    check("idle_uo", int'(uo_out), 0);

    // N=5, single shot
    b0 = busy_tot;
    ui_in = 8'h45;
    step(2);
    check("lat_before_3rd", int'(uo_out[0]), 0);
    step(1);
    check("lat_3rd_edge", int'(uo_out[0]), 1);
    check("n5_busy_at_start", int'(uo_out[2]), 1);
    step(1);
    check("n5_start_1cyc", int'(uo_out[0]), 0);
    wait_bit(3, 100, "n5_done_seen");
    check("n5_interval", t_stop - t_start, 5);
    check("n5_busy_cycles", busy_tot - b0, 6);
    check("n5_done_lag", cyc - t_stop, 1);
    check("n5_count", int'(uo_out[7:4]), 1);
    check("n5_busy_off", int'(uo_out[2]), 0);
    ui_in = 8'h00;
    step(3);
    check("done_held", int'(uo_out[3]), 1);

    // N=0 zero-interval calibration
    b0 = busy_tot;
    ui_in = 8'h40;
    wait_bit(0, 20, "n0_start_seen");
    check("n0_stop_same_cycle", int'(uo_out[1]), 1);
    check("n0_done_cleared", int'(uo_out[3]), 0);
    wait_bit(3, 20, "n0_done_seen");
    check("n0_busy_cycles", busy_tot - b0, 1);
    check("n0_count", int'(uo_out[7:4]), 2);
    ui_in = 8'h00;
    step(3);

    // N=63, interval and repeat bit changed mid-WAIT
    s0 = n_start;
    ui_in = 8'h7F;
    wait_bit(0, 20, "n63_start_seen");
    step(10);
    ui_in = 8'hC2;
    wait_bit(3, 200, "n63_done_seen");
    check("n63_interval", t_stop - t_start, 63);
    check("n63_count", int'(uo_out[7:4]), 3);
    step(HOLDOFF + 6);
    check("n63_no_repeat", n_start - s0, 1);
    ui_in = 8'h00;
    step(3);

    // repeat, N=3: start-to-start = 1 + 2 + 1 + HOLDOFF
    ui_in = 8'hC3;
    wait_bit(0, 20, "rep_start1");
    t1 = cyc;
    check("rep_count1", int'(uo_out[7:4]), 3);
    wait_bit(0, 20, "rep_start2");
    t2 = cyc;
    check("rep_period1", t2 - t1, 8);
    check("rep_count2", int'(uo_out[7:4]), 4);
    wait_bit(0, 20, "rep_start3");
    t3 = cyc;
    check("rep_period2", t3 - t2, 8);
    check("rep_count3", int'(uo_out[7:4]), 5);
    ui_in = 8'h83;
    step(1);
    s0 = n_start;
    wait_bit(3, 20, "rep_last_done");
    step(HOLDOFF + 8);
    check("rep_stopped", n_start - s0, 0);
    check("rep_count_end", int'(uo_out[7:4]), 6);
    check("rep_idle", int'(uo_out[2]), 0);
    ui_in = 8'h00;
    step(3);

    // async reset in WAIT with go held high
    ui_in = 8'h54;
    wait_bit(0, 20, "rst_start_seen");
    step(5);
    check("rst_in_wait_busy", int'(uo_out[2]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_uo", int'(uo_out), 0);
    step(2);
    rst_n = 1'b1;
    s0 = n_start;
    step(30);
    check("rst_go_held_no_start", n_start - s0, 0);
    check("rst_count_clr", int'(uo_out[7:4]), 0);
    ui_in = 8'h14;
    step(3);
    ui_in = 8'h54;
    wait_bit(0, 20, "rst_fresh_go_start");
    wait_bit(3, 40, "rst_fresh_go_done");
    check("rst_fresh_count", int'(uo_out[7:4]), 1);

    // second go rise during WAIT is ignored
    ui_in = 8'h0A;
    step(3);
    s0 = n_start;
    p0 = n_stop;
    ui_in = 8'h4A;
    wait_bit(0, 20, "dbl_start_seen");
    step(3);
    ui_in = 8'h0A;
    step(3);
    ui_in = 8'h4A;
    wait_bit(3, 30, "dbl_done_seen");
    step(12);
    check("dbl_one_start", n_start - s0, 1);
    check("dbl_one_stop", n_stop - p0, 1);
    check("dbl_interval", t_stop - t_start, 10);
    check("dbl_count", int'(uo_out[7:4]), 2);

    // 17 single N=1 bursts from reset: count wraps to 1
    rst_n = 1'b0;
    ui_in = 8'h01;
    step(1);
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 17; i++) begin
      ui_in = 8'h01;
      step(3);
      ui_in = 8'h41;
      wait_bit(0, 20, "wrap_start");
      wait_bit(3, 20, "wrap_done");
    end
    check("wrap_n1_interval", t_stop - t_start, 1);
    check("wrap_count", int'(uo_out[7:4]), 1);

    check("start_pulse_width", start_long, 0);
    check("stop_pulse_width", stop_long, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
